axi_lite_regfile: RTL and testbench
===================================

Name: axi_lite_regfile

Overview:
- AXI4-Lite register-bank target; sits directly downstream of AXI_MASTER and consumes its AR/R/AW/W/B channels.
- Holds NUM_REGS 32-bit control/status registers with byte-strobe writes.
- Exposes register contents and per-register write pulses to downstream logic.
- One outstanding read and one outstanding write; read and write paths are independent.

Parameters:
NUM_REGS, 16, number of 32-bit registers (1..256)
BASE_ADDR, 32'h0000_0000, byte address of register 0
ADDR_LSB, 2, word-offset shift; register index = (ADDR - BASE_ADDR) >> ADDR_LSB

Ports:
clk  input  1  single clock
rst  input  1  synchronous, active-high reset
ARVALID  input  1  read address valid
ARADDR  input  32  read byte address
ARPROT  input  3  read protection
ARREADY  output  1  read address accepted
RVALID  output  1  read data valid
RREADY  input  1  master accepts read data
RDATA  output  32  read data
RRESP  output  2  read response (00 OKAY, 10 SLVERR)
AWVALID  input  1  write address valid
AWADDR  input  32  write byte address
AWPROT  input  3  write protection
AwREADY  output  1  write address accepted
WDATA  input  32  write data
WSTRB  input  4  byte enables
WVALID  input  1  write data valid
WREADY  output  1  write data accepted
BVALID  output  1  write response valid
BREADY  input  1  master accepts response
BRESP  output  2  write response
reg_out  output  NUM_REGS*32  flat register contents; reg i at [32*i+31:32*i]
wr_pulse  output  NUM_REGS  one-cycle pulse on the cycle a register is updated

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst high at a clk edge) clears:
  - all registers to 0; RVALID, BVALID, wr_pulse to 0; RDATA 0; RRESP/BRESP 00.
  - AW/W holding flags (in-flight transactions are dropped, no response issued).
- ARREADY, AwREADY, WREADY are forced 0 while rst is high.
- Decode:
  - offset = ADDR - BASE_ADDR; index = offset >> ADDR_LSB; low ADDR_LSB bits ignored.
  - Valid when ADDR >= BASE_ADDR and index < NUM_REGS; otherwise SLVERR.
- Write path:
  - AW and W are accepted independently, in either order. Each is latched into its own holding register with flags aw_full and w_full.
  - AwREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
  - Commit when both are held (including both handshaking in the same cycle N):
    - on edge N+1, bytes with WSTRB[b]=1 are written to reg[index];
    - wr_pulse[index]=1 for that one cycle;
    - BVALID=1 and BRESP=00.
  - Decode error: no register change, no wr_pulse, BRESP=10.
  - WSTRB=0000 to a valid index: no byte changes, BRESP=00, wr_pulse still fires.
  - BVALID and BRESP are held until BREADY is high at an edge; that edge clears BVALID and both flags.
  - New AW/W are accepted from the next cycle.
- Read path:
  - ARREADY = !RVALID.
  - AR handshake at edge N: RDATA/RRESP are captured from the register array's value before that edge, and RVALID=1 from N+1.
  - Decode error: RDATA=0, RRESP=10.
  - RVALID/RDATA/RRESP are stable until RREADY is high at an edge. With RREADY already high, back-to-back reads sustain one read per 2 cycles.
- Simultaneous events:
  - Write commit and AR handshake to the same register on the same edge: the read returns the pre-write value.
  - Read and write channels never stall each other.
- ARPROT/AWPROT are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: AXI_REGFILE_PROT_CHECK_EN.
- Defined: any access with xPROT[0]=0 (unprivileged) gets SLVERR.
  - Write: no update, no wr_pulse.
  - Read: RDATA=0.
  - Register NUM_REGS-1 is reserved as a sticky violation counter: saturating 32-bit, incremented per rejected access, read-only (writes get SLVERR).
- Undefined: PROT inputs are unused; all registers are read/write.

Test Plan:
- Reset, then read addr 0x0C with ARPROT=001 -> RVALID one cycle after handshake, RDATA=0, RRESP=00; ARREADY low while RVALID is held and RREADY=0.
- AW 0x04 and W 0xDEADBEEF, WSTRB=1111 in the same cycle -> next cycle wr_pulse[1]=1, BVALID=1, BRESP=00; read 0x04 returns 0xDEADBEEF.
- W first (0x11223344, WSTRB=0101), AW 0x04 three cycles later -> reg1=0xDE22BE44 after commit; BREADY held 0 for 4 cycles keeps BVALID/BRESP stable, AwREADY=WREADY=0.
- Write and read 0x40 with NUM_REGS=16 -> BRESP=10, RRESP=10, RDATA=0, no wr_pulse, no register changes.
- Read reg 2 on the same edge its write of 0xA5A5A5A5 commits (old value 0) -> RDATA=0; a following read returns 0xA5A5A5A5.
- rst asserted with aw_full=1 and BVALID pending -> next cycle BVALID=0, all reg_out=0; with the macro defined, AWPROT=000 to 0x00 -> BRESP=10 and reg15 (NUM_REGS=16) reads 1.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit registers with byte-strobe writes, flat register output and per-register write pulses.
// Optional AXI_REGFILE_PROT_CHECK_EN: unprivileged accesses get SLVERR and the top register counts them.
module axi_lite_regfile #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_LSB  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ARVALID,
  input  logic [31:0]           ARADDR,
  input  logic [2:0]            ARPROT,
  output logic                  ARREADY,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  input  logic                  AWVALID,
  input  logic [31:0]           AWADDR,
  input  logic [2:0]            AWPROT,
  output logic                  AwREADY,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic [NUM_REGS-1:0]   wr_pulse
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] regs [NUM_REGS];

  logic        aw_full, w_full;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;

  logic             ar_hs, aw_hs, w_hs, commit;
  logic [31:0]      wr_addr, wr_data;
  logic [3:0]       wr_strb;
  logic             wr_ok, rd_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> ADDR_LSB) < 32'(NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE_ADDR) >> ADDR_LSB;
    return IDX_W'(off);
  endfunction

  assign ARREADY = !rst && !RVALID;
  assign AwREADY = !rst && !aw_full && !BVALID;
  assign WREADY  = !rst && !w_full && !BVALID;

  assign ar_hs = ARVALID && ARREADY;
  assign aw_hs = AWVALID && AwREADY;
  assign w_hs  = WVALID && WREADY;

  // A channel arriving this cycle is used directly so same-cycle AW+W commits at once
  assign wr_addr = aw_full ? aw_addr_q : AWADDR;
  assign wr_data = w_full ? w_data_q : WDATA;
  assign wr_strb = w_full ? w_strb_q : WSTRB;
  assign commit  = !BVALID && (aw_full || aw_hs) && (w_full || w_hs);

  assign wr_idx = addr_index(wr_addr);
  assign rd_idx = addr_index(ARADDR);

`ifdef AXI_REGFILE_PROT_CHECK_EN
  logic        aw_priv_q;
  logic        wr_priv, rd_viol, wr_viol;
  logic [1:0]  viol_n;
  logic [32:0] cnt_sum;
  logic        unused_prot;

  assign wr_priv = aw_full ? aw_priv_q : AWPROT[0];
  assign wr_ok   = addr_in_range(wr_addr) && wr_priv && (wr_idx != IDX_W'(NUM_REGS - 1));
  assign rd_ok   = addr_in_range(ARADDR) && ARPROT[0];
  assign rd_viol = ar_hs && !ARPROT[0];
  assign wr_viol = commit && !wr_priv;
  assign viol_n  = 2'(rd_viol) + 2'(wr_viol);
  assign cnt_sum = {1'b0, regs[NUM_REGS-1]} + 33'(viol_n);
  assign unused_prot = ^{ARPROT[2:1], AWPROT[2:1]};

  // Privilege bit of the held write address
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_priv_q <= 1'b0;
    end else if (aw_hs) begin
      aw_priv_q <= AWPROT[0];
    end
  end
`else
  logic unused_prot;

  assign wr_ok = addr_in_range(wr_addr);
  assign rd_ok = addr_in_range(ARADDR);
  assign unused_prot = ^{ARPROT, AWPROT};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      RVALID    <= 1'b0;
      RDATA     <= '0;
      RRESP     <= RESP_OKAY;
      wr_pulse  <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end

      // Flags stay set while the response is pending; BREADY releases both
      if (commit) begin
        BVALID <= 1'b1;
        BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
          end
          wr_pulse[wr_idx] <= 1'b1;
        end
      end else if (BVALID && BREADY) begin
        BVALID  <= 1'b0;
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end

      if (ar_hs) begin
        RVALID <= 1'b1;
        RDATA  <= rd_ok ? regs[rd_idx] : 32'h0;
        RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (RVALID && RREADY) begin
        RVALID <= 1'b0;
      end

`ifdef AXI_REGFILE_PROT_CHECK_EN
      if (viol_n != 2'd0) begin
        regs[NUM_REGS-1] <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
      end
`endif
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[32*i +: 32] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Randomized + directed bench for axi_lite_regfile against a transaction-level model.
module tb_axi_lite_regfile;

  localparam int NUM = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef AXI_REGFILE_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] ARADDR, RDATA;
  logic [2:0] ARPROT, AWPROT;
  logic [1:0] RRESP, BRESP;
  logic AWVALID, AwREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA;
  logic [3:0] WSTRB;
  logic [NUM*32-1:0] reg_out;
  logic [NUM-1:0] wr_pulse;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_regfile #(.NUM_REGS(NUM), .BASE_ADDR(BASE), .ADDR_LSB(2)) dut (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWPROT(AWPROT), .AwREADY(AwREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [NUM];
  logic [31:0] m_before [NUM];
  bit          m_started = 1'b0;
  bit          m_awf, m_wf, m_bvalid, m_rvalid;
  logic [31:0] m_awaddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_awprot;
  logic [1:0]  m_rresp, m_bresp;
  logic [NUM-1:0] m_pulse;

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 32'd4) < 32'(NUM));
  endfunction

  always @(posedge clk) begin
    bit was_b, was_r, ok;
    int idx, viol;
    if (rst) begin
      for (int i = 0; i < NUM; i++) m_regs[i] = '0;
      m_awf = 0; m_wf = 0; m_bvalid = 0; m_rvalid = 0;
      m_rdata = '0; m_rresp = 2'b00; m_bresp = 2'b00; m_pulse = '0;
      m_started = 1'b1;
    end else if (m_started) begin
      was_b = m_bvalid;
      was_r = m_rvalid;
      viol = 0;
      m_before = m_regs;
      m_pulse = '0;
      if (AWVALID && !m_awf && !was_b) begin
        m_awf = 1; m_awaddr = AWADDR; m_awprot = AWPROT;
      end
      if (WVALID && !m_wf && !was_b) begin
        m_wf = 1; m_wdata = WDATA; m_wstrb = WSTRB;
      end
      if (!was_b && m_awf && m_wf) begin
        idx = int'((m_awaddr - BASE) / 32'd4);
        ok = in_range(m_awaddr);
        if (PROT_EN) begin
          if (!m_awprot[0]) viol++;
          ok = ok && m_awprot[0] && (idx != NUM - 1);
        end
        m_bvalid = 1;
        m_bresp = ok ? 2'b00 : 2'b10;
        if (ok) begin
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) m_regs[idx][8*b +: 8] = m_wdata[8*b +: 8];
          m_pulse[idx] = 1'b1;
        end
      end else if (was_b && BREADY) begin
        m_bvalid = 0; m_awf = 0; m_wf = 0;
      end
      if (ARVALID && !was_r) begin
        ok = in_range(ARADDR);
        if (PROT_EN) begin
          if (!ARPROT[0]) viol++;
          ok = ok && ARPROT[0];
        end
        m_rvalid = 1;
        m_rdata = ok ? m_before[int'((ARADDR - BASE) / 32'd4)] : 32'h0;
        m_rresp = ok ? 2'b00 : 2'b10;
      end else if (was_r && RREADY) begin
        m_rvalid = 0;
      end
      if (viol > 0)
        m_regs[NUM-1] = (m_regs[NUM-1] > 32'hFFFF_FFFF - 32'(viol)) ? 32'hFFFF_FFFF : m_regs[NUM-1] + 32'(viol);
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_started) begin
      chk("ARREADY", ARREADY, !rst && !m_rvalid);
      chk("AwREADY", AwREADY, !rst && !m_awf && !m_bvalid);
      chk("WREADY",  WREADY,  !rst && !m_wf && !m_bvalid);
      chk("RVALID",  RVALID,  m_rvalid);
      chk("RDATA",   RDATA,   m_rdata);
      chk("RRESP",   RRESP,   m_rresp);
      chk("BVALID",  BVALID,  m_bvalid);
      chk("BRESP",   BRESP,   m_bresp);
      chk("wr_pulse", wr_pulse, m_pulse);
      for (int i = 0; i < NUM; i++)
        chk($sformatf("reg_out[%0d]", i), reg_out[32*i +: 32], m_regs[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ARVALID = 0; AWVALID = 0; WVALID = 0; RREADY = 0; BREADY = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int hold,
                         output logic [31:0] data, output logic [1:0] resp);
    int n;
    ARVALID = 1; ARADDR = addr; ARPROT = prot; RREADY = 0;
    step();
    n = 0;
    while (!RVALID && n < 20) begin step(); n++; end
    ARVALID = 0;
    chk("read_rvalid_arrives", RVALID, 1'b1);
    data = RDATA;
    resp = RRESP;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("read_hold_arready_low", ARREADY, 1'b0);
      chk("read_hold_rdata_stable", RDATA, data);
    end
    RREADY = 1;
    step();
    RREADY = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input int lag, input int hold,
                          output logic [1:0] resp, output logic [NUM-1:0] pulse);
    int n;
    WVALID = 1; WDATA = data; WSTRB = strb; BREADY = 0;
    if (lag == 0) begin AWVALID = 1; AWADDR = addr; AWPROT = prot; end
    step();
    WVALID = 0;
    if (lag > 0) begin
      for (int i = 1; i < lag; i++) step();
      AWVALID = 1; AWADDR = addr; AWPROT = prot;
      step();
    end
    AWVALID = 0;
    n = 0;
    while (!BVALID && n < 20) begin step(); n++; end
    chk("write_bvalid_arrives", BVALID, 1'b1);
    resp = BRESP;
    pulse = wr_pulse;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("b_hold_bvalid", BVALID, 1'b1);
      chk("b_hold_bresp", BRESP, resp);
      chk("b_hold_awready", AwREADY, 1'b0);
      chk("b_hold_wready", WREADY, 1'b0);
    end
    BREADY = 1;
    step();
    BREADY = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 19)) * 32'd4 + 32'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) a = $urandom;
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0] r;
    logic [NUM-1:0] p;

    rst = 1; idle();
    ARADDR = 0; ARPROT = 0; AWADDR = 0; AWPROT = 0; WDATA = 0; WSTRB = 0;
    repeat (3) step();
    rst = 0;
    step();

    // read of a reset register, RVALID held with RREADY low
    do_read(32'h0C, 3'b001, 2, d, r);
    chk("t1_rdata", d, 32'h0);
    chk("t1_rresp", r, 2'b00);

    // same-cycle AW+W
    do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 0, r, p);
    chk("t2_bresp", r, 2'b00);
    chk("t2_pulse", p, 16'h0002);
    do_read(32'h04, 3'b001, 0, d, r);
    chk("t2_rdata", d, 32'hDEAD_BEEF);

    // W leads AW by three cycles, partial strobe, slow BREADY
    do_write(32'h04, 32'h1122_3344, 4'b0101, 3'b001, 3, 4, r, p);
    chk("t3_bresp", r, 2'b00);
    chk("t3_reg1", reg_out[63:32], 32'hDE22_BE44);

    // zero strobe still pulses, leaves data alone
    do_write(32'h14, 32'hFFFF_FFFF, 4'b0000, 3'b001, 0, 0, r, p);
    chk("t3b_bresp", r, 2'b00);
    chk("t3b_pulse", p, 16'h0020);
    chk("t3b_reg5", reg_out[191:160], 32'h0);

    // out-of-range access
    do_write(32'h40, 32'h1234_5678, 4'hF, 3'b001, 0, 0, r, p);
    chk("t4_bresp", r, 2'b10);
    chk("t4_pulse", p, 16'h0);
    do_read(32'h40, 3'b001, 0, d, r);
    chk("t4_rresp", r, 2'b10);
    chk("t4_rdata", d, 32'h0);

    // read and write commit to reg2 on the same edge
    AWVALID = 1; AWADDR = 32'h08; AWPROT = 3'b001;
    WVALID = 1; WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF;
    ARVALID = 1; ARADDR = 32'h08; ARPROT = 3'b001;
    step();
    idle();
    chk("t5_rvalid", RVALID, 1'b1);
    chk("t5_rdata_old", RDATA, 32'h0);
    chk("t5_reg2", reg_out[95:64], 32'hA5A5_A5A5);
    RREADY = 1; BREADY = 1;
    step();
    idle();
    do_read(32'h08, 3'b001, 0, d, r);
    chk("t5_rdata_new", d, 32'hA5A5_A5A5);

    // reset with a pending response
    AWVALID = 1; AWADDR = 32'h10; AWPROT = 3'b001;
    WVALID = 1; WDATA = 32'h1234_5678; WSTRB = 4'hF;
    step();
    idle();
    chk("t6_bvalid_pending", BVALID, 1'b1);
    rst = 1;
    step();
    chk("t6_ready_in_reset", {ARREADY, AwREADY, WREADY}, 3'b000);
    rst = 0;
    chk("t6_bvalid_cleared", BVALID, 1'b0);
    chk("t6_regs_cleared", |reg_out, 1'b0);

    // reset drops a held AW: a later W alone must not complete
    AWVALID = 1; AWADDR = 32'h00; AWPROT = 3'b001;
    step();
    AWVALID = 0;
    rst = 1;
    step();
    rst = 0;
    WVALID = 1; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF;
    step();
    WVALID = 0;
    step();
    chk("t6_no_orphan_commit", BVALID, 1'b0);
    chk("t6_reg0_untouched", reg_out[31:0], 32'h0);
    rst = 1;
    step();
    rst = 0;
    step();

`ifdef AXI_REGFILE_PROT_CHECK_EN
    do_write(32'h00, 32'h5555_5555, 4'hF, 3'b000, 0, 0, r, p);
    chk("prot_bresp", r, 2'b10);
    chk("prot_pulse", p, 16'h0);
    do_read(32'h3C, 3'b001, 0, d, r);
    chk("prot_counter", d, 32'h1);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      ARVALID = 1'($urandom_range(0, 1));
      ARADDR  = rand_addr();
      ARPROT  = 3'($urandom);
      RREADY  = ($urandom_range(0, 3) != 0);
      AWVALID = 1'($urandom_range(0, 1));
      AWADDR  = rand_addr();
      AWPROT  = 3'($urandom);
      WVALID  = 1'($urandom_range(0, 1));
      WDATA   = $urandom;
      WSTRB   = 4'($urandom);
      BREADY  = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    idle();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
